// File: rtl/bcd_xs3_seq_if.sv
// bcd_xs3_seq_if: handshake bundle for the sequential BCD to excess-3 converter.
//   in_valid  : source presents a packed BCD word
//   in_ready  : converter accepts a word (only while idle)
//   in_bcd    : packed BCD word, digit 0 in bits [3:0]
//   out_valid : converted word available
//   out_ready : sink accepts the result
//   out_xs3   : packed excess-3 result, nibble i from BCD digit i
//   out_err   : at least one input digit was greater than 9 (error build only)
//   busy      : converter is working on or holding a word
// Modports: master = source/sink side, slave = converter side.
interface bcd_xs3_seq_if #(
   parameter int unsigned DIGITS = 4
);
   localparam int unsigned W = 4 * DIGITS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_bcd;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_xs3;
   logic         out_err;
   logic         busy;

   modport master (
      output in_valid, in_bcd, out_ready,
      input  in_ready, out_valid, out_xs3, out_err, busy
   );

   modport slave (
      input  in_valid, in_bcd, out_ready,
      output in_ready, out_valid, out_xs3, out_err, busy
   );
endinterface

// File: rtl/bcd_xs3_seq.sv
// bcd_xs3_seq: sequential packed-BCD to excess-3 converter, one digit per cycle.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : bcd_xs3_seq_if.slave (in_valid/in_ready/in_bcd, out_valid/out_ready/
//         out_xs3/out_err, busy)
// Parameter DIGITS: BCD digits per word (1..8).
// Optional feature macro BCD_XS3_ERR_EN: digits above 9 produce nibble 4'hF and
// raise a sticky error shown on out_err; without it every digit is a plain
// modulo-16 add of 3 and out_err is tied low.
module bcd_xs3_seq #(
   parameter int unsigned DIGITS = 4
) (
   input  logic          clk,
   input  logic          rst,
   bcd_xs3_seq_if.slave  bus
);
   localparam int unsigned W     = 4 * DIGITS;
   localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned SH_W  = CNT_W + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       bcd_q, bcd_d;
   logic [W-1:0]       xs3_q, xs3_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic [SH_W-1:0]    sh_c;
   logic [3:0]         digit_c;
   logic [3:0]         nib_c;
`ifdef BCD_XS3_ERR_EN
   logic               err_q, err_d;
   logic               out_err_q, out_err_d;
   logic               bad_c;
`endif

   // Current digit and its excess-3 nibble
   assign sh_c    = {cnt_q, 2'b00};
   assign digit_c = 4'(bcd_q >> sh_c);
`ifdef BCD_XS3_ERR_EN
   assign bad_c   = (digit_c > 4'd9);
   assign nib_c   = bad_c ? 4'hF : 4'(digit_c + 4'd3);
`else
   assign nib_c   = 4'(digit_c + 4'd3);
`endif

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bcd_q       <= '0;
         xs3_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BCD_XS3_ERR_EN
         err_q       <= 1'b0;
         out_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         xs3_q       <= xs3_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef BCD_XS3_ERR_EN
         err_q       <= err_d;
         out_err_q   <= out_err_d;
`endif
      end
   end

   // Next-state, datapath update and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      xs3_d   = xs3_q;
`ifdef BCD_XS3_ERR_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               state_d = CONV;
               bcd_d   = bus.in_bcd;
               cnt_d   = '0;
               xs3_d   = '0;
`ifdef BCD_XS3_ERR_EN
               err_d   = 1'b0;
`endif
            end
         end
         CONV: begin
            // Merge this cycle's nibble into its slot of the result
            xs3_d = (xs3_q & ~(W'(4'hF) << sh_c)) | (W'(nib_c) << sh_c);
`ifdef BCD_XS3_ERR_EN
            err_d = err_q | bad_c;
`endif
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they align with it
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DONE);
`ifdef BCD_XS3_ERR_EN
      out_err_d   = (state_d == DONE) && err_d;
`endif
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_xs3   = xs3_q;
   assign bus.busy      = busy_q;
`ifdef BCD_XS3_ERR_EN
   assign bus.out_err   = out_err_q;
`else
   assign bus.out_err   = 1'b0;
`endif

endmodule

// File: doc/bcd_xs3_seq.md
BCD_XS3_SEQ -- requirements
Module: bcd_xs3_seq

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of packed BCD digits per word (legal 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1, source presents a BCD word.
REQ-005 SHALL have port in_ready, output, 1, block accepts a word (high only in IDLE).
REQ-006 SHALL have port in_bcd, input, 4*DIGITS, packed BCD; digit 0 = bits [3:0].
REQ-007 SHALL have port out_valid, output, 1, converted word available.
REQ-008 SHALL have port out_ready, input, 1, sink accepts the result.
REQ-009 SHALL have port out_xs3, output, 4*DIGITS, packed excess-3 result; nibble i corresponds to in_bcd nibble i.
REQ-010 SHALL have port out_err, output, 1, at least one input digit was greater than 9.
REQ-011 SHALL have port busy, output, 1, high in CONV and DONE.

Function
REQ-012 SHALL implement the FSM states IDLE, CONV and DONE.
REQ-013 SHALL leave IDLE for CONV on the edge where in_valid and in_ready are both high; on that edge it captures in_bcd, clears the digit counter, clears the result and clears the error flag.
REQ-014 SHALL keep in_ready equal to (state == IDLE); a word is never accepted in CONV or DONE.
REQ-015 SHALL, in CONV, convert exactly one digit per cycle, starting with digit 0: result nibble i = digit i + 3, computed as a 4-bit sum (modulo 16), with the counter incrementing by 1.
REQ-016 SHALL move from CONV to DONE on the edge that converts digit DIGITS-1; out_valid SHALL go high in the cycle after acceptance edge + DIGITS edges (latency DIGITS+1 cycles from acceptance to out_valid).
REQ-017 SHALL hold out_valid, out_xs3 and out_err stable in DONE until out_ready is high.
REQ-018 SHALL return from DONE to IDLE on the edge where out_valid and out_ready are both high; in_ready becomes high in the next cycle, so there is no same-cycle accept at handoff.
REQ-019 SHALL hold out_xs3 at its last value outside DONE, and consumers SHALL qualify it with out_valid only.
REQ-020 SHALL ignore in_bcd and in_valid changes after capture, and out_ready outside DONE.
REQ-021 SHALL convert in_bcd = 0 normally: every nibble becomes 4'h3.

Reset
REQ-022 SHALL, when rst is high at a clock edge, set state to IDLE, the counter to 0, out_xs3 to 0, out_err to 0 and out_valid to 0, and drive in_ready to 1 and busy to 0 from the following cycle.
REQ-023 SHALL let rst take priority over every transition, including mid-CONV and DONE with out_ready high; a partially converted word is discarded and no out_valid is produced for it.

Configuration
REQ-024 SHALL support the macro BCD_XS3_ERR_EN.
REQ-025 SHALL, when BCD_XS3_ERR_EN is defined, do both of the following for any digit greater than 9: write nibble 4'hF, and set a sticky error bit that is presented on out_err in DONE.
REQ-026 SHALL, when BCD_XS3_ERR_EN is undefined, convert every digit as a modulo-16 add of 3 and tie out_err to 0; the port is kept.

Verification
REQ-027 SHALL cover: DIGITS=4, accept in_bcd=16'h9370, out_ready=1 -> out_valid 5 cycles after acceptance with out_xs3=16'hC6A3, out_err=0.
REQ-028 SHALL cover: in_bcd=16'h0000 -> out_xs3=16'h3333; then in_bcd=16'h9999 -> out_xs3=16'hCCCC.
REQ-029 SHALL cover: in_bcd=16'h12A4 -> with BCD_XS3_ERR_EN, out_xs3=16'h45F7 and out_err=1; without it, out_xs3=16'h45D7 and out_err=0.
REQ-030 SHALL cover: out_ready held low 6 cycles in DONE -> out_valid and out_xs3 stable, in_ready=0 and busy=1 throughout; out_ready high -> IDLE next edge.
REQ-031 SHALL cover: rst pulsed 1 cycle after the 2nd CONV edge -> out_valid never asserts for that word, in_ready=1 next cycle, and a following 16'h0101 -> 16'h3434.
REQ-032 SHALL cover: in_valid held high continuously with back-to-back words -> exactly one accept per IDLE visit, and no word is lost or duplicated.
